pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush sequencer for the five-stage pipeline, with
//            saturating stall, flush and retire counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        redirect,
    input  logic        memwb_valid,
    output logic        imem_en,
    output logic        dmem_en,
    output logic        dmem_hold,
    output logic        load_pc,
    output logic        load_ifid,
    output logic        load_idex,
    output logic        load_exmem,
    output logic        load_memwb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] retire_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic w_i_out;
    logic w_d_out;
    logic w_stall;
    logic w_take_redirect;

    // A response in the current cycle already satisfies its cache.
    assign w_i_out         = imem_req & ~i_done_q & ~imem_resp;
    assign w_d_out         = dmem_req & ~d_done_q & ~dmem_resp;
    assign w_stall         = w_i_out | w_d_out;
    assign w_take_redirect = redirect & ~w_stall;

    always_comb begin
        state_d  = state_q;
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        case (state_q)
            ST_RUN: begin
                if (w_stall)              state_d  = ST_WAIT;
                if (imem_resp && w_d_out) i_done_d = 1'b1;
                if (dmem_resp && w_i_out) d_done_d = 1'b1;
            end
            ST_WAIT: begin
                if (!w_stall) begin
                    state_d  = ST_RUN;
                    i_done_d = 1'b0;
                    d_done_d = 1'b0;
                end else begin
                    if (imem_resp) i_done_d = 1'b1;
                    if (dmem_resp) d_done_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (w_stall && stall_cnt_q != C_CNT_MAX)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (w_take_redirect && flush_cnt_q != C_CNT_MAX)
            flush_cnt_d = flush_cnt_q + 32'd1;
        if (memwb_valid && !w_stall && retire_cnt_q != C_CNT_MAX)
            retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            stall_cnt_q  <= 32'd0;
            flush_cnt_q  <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Reset overrides everything: strobes off, registers frozen, bubbles in.
    assign imem_en    = ~rst & imem_req & ~i_done_q;
    assign dmem_en    = ~rst & dmem_req & ~d_done_q;
    assign dmem_hold  = ~rst & d_done_q;
    assign load_pc    = ~rst & ~w_stall;
    assign load_ifid  = ~rst & ~w_stall;
    assign load_idex  = ~rst & ~w_stall;
    assign load_exmem = ~rst & ~w_stall;
    assign load_memwb = ~rst & ~w_stall;
    assign flush_ifid = rst | w_take_redirect;
    assign flush_idex = rst | w_take_redirect;

    assign stall_count  = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign retire_count = retire_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed scenarios plus random traffic checked against a
//            behavioural model of the stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_resp, dmem_req, dmem_resp, redirect, memwb_valid;
    logic        imem_en, dmem_en, dmem_hold;
    logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic        flush_ifid, flush_idex;
    logic [31:0] stall_count, flush_count, retire_count;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: which caches have already answered during the current stall.
    bit          m_igot, m_dgot;
    longint      m_sc, m_fc, m_rc;
    logic [9:0]  obs_ctrl;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .redirect(redirect), .memwb_valid(memwb_valid),
        .imem_en(imem_en), .dmem_en(dmem_en), .dmem_hold(dmem_hold),
        .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
        .load_exmem(load_exmem), .load_memwb(load_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .stall_count(stall_count), .flush_count(flush_count),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint sat_inc(input longint v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit r, input bit ir, input bit irs, input bit dr,
                        input bit drs, input bit rd, input bit mv);
        bit         need_stall;
        logic [9:0] exp_ctrl;
        rst = r; imem_req = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
        redirect = rd; memwb_valid = mv;
        need_stall = (ir && !m_igot && !irs) || (dr && !m_dgot && !drs);
        if (r)
            exp_ctrl = 10'b00_0_00000_11;
        else
            exp_ctrl = {ir && !m_igot, dr && !m_dgot, m_dgot,
                        {5{!need_stall}}, {2{rd && !need_stall}}};
        @(negedge clk);
        obs_ctrl = {imem_en, dmem_en, dmem_hold, load_pc, load_ifid, load_idex,
                    load_exmem, load_memwb, flush_ifid, flush_idex};
        chk("ctrl", {22'd0, obs_ctrl}, {22'd0, exp_ctrl});
        chk("stall_count", stall_count, m_sc[31:0]);
        chk("flush_count", flush_count, m_fc[31:0]);
        chk("retire_count", retire_count, m_rc[31:0]);
        @(posedge clk);
        if (r) begin
            m_igot = 0; m_dgot = 0; m_sc = 0; m_fc = 0; m_rc = 0;
        end else begin
            if (need_stall) m_sc = sat_inc(m_sc);
            if (rd && !need_stall) m_fc = sat_inc(m_fc);
            if (mv && !need_stall) m_rc = sat_inc(m_rc);
            if (need_stall) begin
                m_igot = m_igot | irs;
                m_dgot = m_dgot | drs;
            end else begin
                m_igot = 0;
                m_dgot = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        redirect = 0; memwb_valid = 0;
        m_igot = 0; m_dgot = 0; m_sc = 0; m_fc = 0; m_rc = 0;
        @(posedge clk); #1;
        do_reset();

        // I-miss only, response in cycle 4
        for (int c = 0; c < 4; c++) step(0, 1, 0, 0, 0, 0, 1);
        chk("imiss_loads_c3", {27'd0, obs_ctrl[6:2]}, 32'd0);
        step(0, 1, 1, 0, 0, 0, 1);
        chk("imiss_loads_c4", {27'd0, obs_ctrl[6:2]}, 32'h1F);
        chk("imiss_stall_cnt", stall_count, 32'd4);
        chk("imiss_retire_cnt", retire_count, 32'd1);
        idle();
        chk("imiss_after_loads", {27'd0, obs_ctrl[6:2]}, 32'h1F);

        // D answers at cycle 2, I at cycle 5
        do_reset();
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1, 0, 0);
        chk("dfirst_den_c2", {31'd0, obs_ctrl[8]}, 32'd1);
        step(0, 1, 0, 1, 0, 0, 0);
        chk("dfirst_den_c3", {31'd0, obs_ctrl[8]}, 32'd0);
        chk("dfirst_hold_c3", {31'd0, obs_ctrl[7]}, 32'd1);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        chk("dfirst_hold_c5", {31'd0, obs_ctrl[7]}, 32'd1);
        chk("dfirst_loads_c5", {27'd0, obs_ctrl[6:2]}, 32'h1F);
        chk("dfirst_stall_cnt", stall_count, 32'd5);
        idle();
        chk("dfirst_hold_c6", {31'd0, obs_ctrl[7]}, 32'd0);

        // Simultaneous responses at cycle 3
        do_reset();
        for (int c = 0; c < 3; c++) step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0);
        chk("simul_loads_c3", {27'd0, obs_ctrl[6:2]}, 32'h1F);
        chk("simul_hold_c3", {31'd0, obs_ctrl[7]}, 32'd0);
        idle();
        chk("simul_en_after", {30'd0, obs_ctrl[9:8]}, 32'd0);
        chk("simul_stall_cnt", stall_count, 32'd3);

        // Redirect held through a D-miss
        do_reset();
        for (int c = 0; c < 3; c++) step(0, 0, 0, 1, 0, 1, 0);
        chk("redir_flush_c2", {30'd0, obs_ctrl[1:0]}, 32'd0);
        step(0, 0, 0, 1, 1, 1, 0);
        chk("redir_flush_c3", {30'd0, obs_ctrl[1:0]}, 32'd3);
        chk("redir_flush_cnt", flush_count, 32'd1);

        // Stall counter saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_sc = 64'hFFFF_FFFE;
        for (int c = 0; c < 3; c++) step(0, 1, 0, 0, 0, 0, 0);
        chk("sat_stall_cnt", stall_count, 32'hFFFF_FFFF);
        step(0, 1, 1, 0, 0, 0, 0);

        // Reset in the middle of a miss
        do_reset();
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        chk("rstmid_ctrl", {22'd0, obs_ctrl}, 32'h003);
        chk("rstmid_stall_cnt", stall_count, 32'd0);
        step(0, 1, 1, 1, 0, 0, 0);
        chk("rstmid_den", {31'd0, obs_ctrl[8]}, 32'd1);
        chk("rstmid_hold", {31'd0, obs_ctrl[7]}, 32'd0);
        step(0, 0, 0, 1, 1, 0, 0);

        // Random traffic, with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
